cda_peak_detect: RTL and testbench

Downstream stage of the CDA correlation-delay array. Consumes the per-lag coincidence bits produced each sample by the CCD stage chain, accumulates them over a fixed window, then finds the lag with the highest coincidence count. It reports that lag index and its count to the time-delay estimation logic. Counters are double-buffered, so no samples are dropped while the argmax scan runs.

---
 rtl/cda_peak_detect_if.sv | 24 ++
 rtl/cda_peak_detect.sv | 120 ++++++++++++
 tb/tb_cda_peak_detect.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cda_peak_detect_if.sv
// Sample/result bundle between the CCD chain, the peak detector and the
// time-delay estimator.
interface cda_peak_detect_if #(
  parameter int STAGES = 16,
  parameter int CNT_W  = 12,
  parameter int IDX_W  = $clog2(STAGES)
);
  logic              en;
  logic [STAGES-1:0] cc_in;
  logic [IDX_W-1:0]  lag_idx;
  logic [CNT_W-1:0]  peak_val;
  logic              out_valid;
  logic              busy;

  modport master (
    output en, cc_in,
    input  lag_idx, peak_val, out_valid, busy
  );

  modport slave (
    input  en, cc_in,
    output lag_idx, peak_val, out_valid, busy
  );
endinterface

// File: rtl/cda_peak_detect.sv
// Per-lag coincidence accumulator with a double-buffered bank and a
// one-lag-per-cycle argmax scan over the completed window.
module cda_peak_detect #(
  parameter int STAGES  = 16,
  parameter int CNT_W   = 12,
  parameter int WIN_LEN = 1024,
  parameter int IDX_W   = $clog2(STAGES)
) (
  input  logic               clk,
  input  logic               rst,
  cda_peak_detect_if.slave   bus
);

  localparam int SCNT_W = $clog2(WIN_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt [STAGES];
  logic [CNT_W-1:0]  shd [STAGES];
  logic [SCNT_W-1:0] scnt;
  logic [IDX_W-1:0]  k;
  logic [IDX_W-1:0]  best_idx;
  logic [CNT_W-1:0]  best_val;
  logic [IDX_W-1:0]  lag_idx_q;
  logic [CNT_W-1:0]  peak_val_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              win_end;
  logic              scan_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic b);
    return (b && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  assign win_end   = bus.en && (scnt == SCNT_W'(WIN_LEN - 1));
  assign scan_last = (k == IDX_W'(STAGES - 1));

  // The final sample of a window lands in the shadow bank, never in cnt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scnt <= '0;
      for (int i = 0; i < STAGES; i++) begin
        cnt[i] <= '0;
        shd[i] <= '0;
      end
    end else if (bus.en) begin
      if (win_end) begin
        scnt <= '0;
        for (int i = 0; i < STAGES; i++) begin
          shd[i] <= sat_inc(cnt[i], bus.cc_in[i]);
          cnt[i] <= '0;
        end
      end else begin
        scnt <= scnt + SCNT_W'(1);
        for (int i = 0; i < STAGES; i++) begin
          cnt[i] <= sat_inc(cnt[i], bus.cc_in[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_end) state_nxt = S_SCAN;
      S_SCAN:  if (scan_last) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy stays up through the cycle in which out_valid is presented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k           <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      lag_idx_q   <= '0;
      peak_val_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= (state == S_OUT);
      busy_q      <= (state != S_IDLE) || (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (win_end) begin
            k        <= '0;
            best_idx <= '0;
            best_val <= '0;
          end
        end
        S_SCAN: begin
          if (shd[k] > best_val) begin
            best_val <= shd[k];
            best_idx <= k;
          end
          k <= k + IDX_W'(1);
        end
        S_OUT: begin
          lag_idx_q  <= best_idx;
          peak_val_q <= best_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.lag_idx   = lag_idx_q;
  assign bus.peak_val  = peak_val_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cda_peak_detect.sv
// Bench for cda_peak_detect: a wide-counter and a saturating (CNT_W=3) instance
// share stimulus and are checked every cycle against a window-sum model.
module tb_cda_peak_detect;

  localparam int STG = 8;
  localparam int WIN = 16;
  localparam int CW0 = 12;
  localparam int CW1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cda_peak_detect_if #(.STAGES(STG), .CNT_W(CW0)) bus0 ();
  cda_peak_detect_if #(.STAGES(STG), .CNT_W(CW1)) bus1 ();

  cda_peak_detect #(.STAGES(STG), .CNT_W(CW0), .WIN_LEN(WIN)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  cda_peak_detect #(.STAGES(STG), .CNT_W(CW1), .WIN_LEN(WIN)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: plain per-lag sums of the current window, the enabled
  // sample count, and edges elapsed since the last window end (-1 = idle).
  int sum [STG];
  int samp;
  int d;
  int pend_lag [2];
  int pend_peak [2];
  int held_lag [2];
  int held_peak [2];

  task automatic modelReset();
    for (int i = 0; i < STG; i++) sum[i] = 0;
    samp = 0;
    d = -1;
    for (int n = 0; n < 2; n++) begin
      pend_lag[n] = 0; pend_peak[n] = 0;
      held_lag[n] = 0; held_peak[n] = 0;
    end
  endtask

  task automatic computePeak();
    int cap, best, idx, v;
    for (int n = 0; n < 2; n++) begin
      cap  = (n == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
      best = 0;
      idx  = 0;
      for (int i = 0; i < STG; i++) begin
        v = (sum[i] > cap) ? cap : sum[i];
        if (v > best) begin best = v; idx = i; end
      end
      pend_lag[n]  = idx;
      pend_peak[n] = best;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkCycle();
    int ov, bz;
    ov = (d == STG + 1) ? 1 : 0;
    bz = (d >= 0) ? 1 : 0;
    checkOutput("dut0.out_valid", 32'(bus0.out_valid), ov);
    checkOutput("dut0.busy",      32'(bus0.busy),      bz);
    checkOutput("dut0.lag_idx",   32'(bus0.lag_idx),   held_lag[0]);
    checkOutput("dut0.peak_val",  32'(bus0.peak_val),  held_peak[0]);
    checkOutput("dut1.out_valid", 32'(bus1.out_valid), ov);
    checkOutput("dut1.busy",      32'(bus1.busy),      bz);
    checkOutput("dut1.lag_idx",   32'(bus1.lag_idx),   held_lag[1]);
    checkOutput("dut1.peak_val",  32'(bus1.peak_val),  held_peak[1]);
  endtask

  // One clock: drive at negedge, let the edge happen, advance the model, check.
  task automatic applyStimulus(input logic e, input logic [STG-1:0] c, input logic r);
    @(negedge clk);
    rst = r;
    bus0.en = e; bus0.cc_in = c;
    bus1.en = e; bus1.cc_in = c;
    @(posedge clk);
    if (!r) begin
      modelReset();
    end else begin
      if (d >= 0) begin
        d++;
        if (d == STG + 2) d = -1;
      end
      if (e) begin
        for (int i = 0; i < STG; i++) if (c[i]) sum[i]++;
        samp++;
        if (samp == WIN) begin
          computePeak();
          for (int i = 0; i < STG; i++) sum[i] = 0;
          samp = 0;
          d = 0;
        end
      end
      if (d == STG + 1) begin
        for (int n = 0; n < 2; n++) begin
          held_lag[n]  = pend_lag[n];
          held_peak[n] = pend_peak[n];
        end
      end
    end
    #1;
    checkCycle();
  endtask

  task automatic runSamples(input int count, input logic [STG-1:0] c);
    for (int n = 0; n < count; n++) applyStimulus(1'b1, c, 1'b1);
  endtask

  task automatic runIdle(input int count);
    for (int n = 0; n < count; n++) applyStimulus(1'b0, STG'($urandom), 1'b1);
  endtask

  initial begin
    bus0.en = 1'b0; bus0.cc_in = '0;
    bus1.en = 1'b0; bus1.cc_in = '0;
    modelReset();

    $display("[TB] reset");
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("reset lag_idx", 32'(bus0.lag_idx), 0);
    checkOutput("reset busy", 32'(bus0.busy), 0);

    $display("[TB] single hot lag");
    runSamples(WIN, 8'h10);
    runIdle(12);
    checkOutput("hot lag0", 32'(bus0.lag_idx), 4);
    checkOutput("hot peak0", 32'(bus0.peak_val), 16);
    checkOutput("hot peak1 sat", 32'(bus1.peak_val), 7);

    $display("[TB] tie between lags 2 and 5");
    runSamples(10, 8'h24);
    runSamples(6, 8'h00);
    runIdle(12);
    checkOutput("tie lag", 32'(bus0.lag_idx), 2);
    checkOutput("tie peak", 32'(bus0.peak_val), 10);

    $display("[TB] all-zero window");
    runSamples(WIN, 8'h00);
    runIdle(12);
    checkOutput("zero lag", 32'(bus0.lag_idx), 0);
    checkOutput("zero peak", 32'(bus0.peak_val), 0);

    $display("[TB] en toggling");
    for (int n = 0; n < 2 * WIN; n++) applyStimulus(n % 2 == 0, 8'h01, 1'b1);
    runIdle(12);
    checkOutput("toggle lag", 32'(bus0.lag_idx), 0);
    checkOutput("toggle peak", 32'(bus0.peak_val), 16);

    $display("[TB] back-to-back windows");
    runSamples(WIN, 8'h80);
    runSamples(WIN, 8'h02);
    checkOutput("b2b first lag", 32'(bus0.lag_idx), 7);
    checkOutput("b2b first peak", 32'(bus0.peak_val), 16);
    runIdle(12);
    checkOutput("b2b second lag", 32'(bus0.lag_idx), 1);
    checkOutput("b2b second peak", 32'(bus0.peak_val), 16);

    $display("[TB] reset during scan");
    for (int n = 0; n < WIN; n++) applyStimulus(1'b1, STG'($urandom), 1'b1);
    runIdle(3);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midscan busy", 32'(bus0.busy), 0);
    checkOutput("midscan out_valid", 32'(bus0.out_valid), 0);
    checkOutput("midscan lag", 32'(bus0.lag_idx), 0);
    checkOutput("midscan peak", 32'(bus0.peak_val), 0);
    runIdle(12);
    runSamples(WIN, 8'h10);
    runIdle(12);
    checkOutput("post-reset lag", 32'(bus0.lag_idx), 4);
    checkOutput("post-reset peak", 32'(bus0.peak_val), 16);

    $display("[TB] saturation");
    runSamples(WIN, 8'h08);
    runIdle(12);
    checkOutput("sat lag1", 32'(bus1.lag_idx), 3);
    checkOutput("sat peak1", 32'(bus1.peak_val), 7);
    checkOutput("sat peak0", 32'(bus0.peak_val), 16);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++)
      applyStimulus($urandom_range(0, 3) != 0, STG'($urandom), 1'b1);
    runIdle(14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
